// File: rtl/addsub_accum_seg.sv
// Handshaked add/sub/load/clear accumulator with multiplexed hex 7-segment scanner.
// Latency 2 edges accept->result; in_ready low during EXEC (one op per 2 cycles).
module addsub_accum_seg #(
  parameter  int WIDTH    = 8,
  parameter  int SCAN_DIV = 4,
  localparam int DIGITS   = (WIDTH + 3) / 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  operand,
  output logic [WIDTH-1:0]  acc,
  output logic              cout,
  output logic              ovf,
  output logic              done,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] dig_sel
);

  localparam int CNTW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SCAN_DIV - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_e;

  typedef struct packed {
    op_e              op;
    logic [WIDTH-1:0] operand;
  } cmd_t;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_accept;
  logic             w_retire;
  logic             w_in_ready;
  cmd_t             r_cmd;

  logic [WIDTH-1:0] r_acc;
  logic             r_cout;
  logic             r_ovf;
  logic             r_done;

  logic [WIDTH-1:0] w_b;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;

  logic [CNTW-1:0]       r_scan_cnt;
  logic [IDXW-1:0]       r_idx;
  logic                  w_cnt_wrap;
  logic [DIGITS*4-1:0]   w_acc_pad;
  logic [3:0]            w_nib;
  logic [6:0]            r_seg;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0:    hex_glyph = 7'b1000000;
      4'h1:    hex_glyph = 7'b1111001;
      4'h2:    hex_glyph = 7'b0100100;
      4'h3:    hex_glyph = 7'b0110000;
      4'h4:    hex_glyph = 7'b0011001;
      4'h5:    hex_glyph = 7'b0010010;
      4'h6:    hex_glyph = 7'b0000010;
      4'h7:    hex_glyph = 7'b1111000;
      4'h8:    hex_glyph = 7'b0000000;
      4'h9:    hex_glyph = 7'b0010000;
      4'hA:    hex_glyph = 7'b0001000;
      4'hB:    hex_glyph = 7'b0000011;
      4'hC:    hex_glyph = 7'b1000110;
      4'hD:    hex_glyph = 7'b0100001;
      4'hE:    hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_retire    = 1'b0;
    w_in_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_retire    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)           r_cmd <= '0;
    else if (w_accept) r_cmd <= '{op: op_e'(op), operand: operand};
  end

  // SUB is acc + ~operand + 1, so the carry reads as "no borrow"
  assign w_b   = (r_cmd.op == OP_SUB) ? ~r_cmd.operand : r_cmd.operand;
  assign w_cin = (r_cmd.op == OP_SUB);
  assign w_sum = {1'b0, r_acc} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
  assign w_ovf = (r_acc[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_acc[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_retire;
      if (w_retire) begin
        case (r_cmd.op)
          OP_LOAD: begin
            r_acc  <= r_cmd.operand;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
          end
          OP_ADD, OP_SUB: begin
            r_acc  <= w_sum[WIDTH-1:0];
            r_cout <= w_sum[WIDTH];
            r_ovf  <= w_ovf;
          end
          default: begin
            r_acc  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign w_cnt_wrap = (r_scan_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (w_cnt_wrap) begin
      r_scan_cnt <= '0;
      r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // Zero-extend so the top digit's unused nibble bits read as 0
  always_comb begin
    w_acc_pad              = '0;
    w_acc_pad[WIDTH-1:0]   = r_acc;
  end

  assign w_nib = w_acc_pad[int'(r_idx) * 4 +: 4];

  always_ff @(posedge clk) begin
    if (rst) r_seg <= 7'b1000000;
    else     r_seg <= hex_glyph(w_nib);
  end

  assign in_ready = w_in_ready;
  assign acc      = r_acc;
  assign cout     = r_cout;
  assign ovf      = r_ovf;
  assign done     = r_done;
  assign seg      = r_seg;
  assign dig_sel  = DIGITS'(1) << r_idx;

endmodule

// File: tb/tb_addsub_accum_seg.sv
// Randomized + directed bench for addsub_accum_seg against a transaction-level model.
module tb_addsub_accum_seg;
  localparam int W  = 8;
  localparam int SD = 4;
  localparam int DG = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [W-1:0]  operand;
  logic [W-1:0]  acc;
  logic          cout;
  logic          ovf;
  logic          done;
  logic [6:0]    seg;
  logic [DG-1:0] dig_sel;

  always #5 clk = ~clk;

  addsub_accum_seg #(.WIDTH(W), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand(operand), .acc(acc), .cout(cout), .ovf(ovf),
    .done(done), .seg(seg), .dig_sel(dig_sel)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int         m_acc  = 0;
  int         m_cout = 0;
  int         m_ovf  = 0;
  int         s_t    = 0;
  bit         s_live = 1'b0;
  logic [6:0] s_seg  = 7'h40;
  int         n_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  task automatic model(input int o, input int d);
    int s, sa;
    case (o)
      0: begin m_acc = d; m_cout = 0; m_ovf = 0; end
      1, 2: begin
        if (o == 1) begin s = m_acc + d;             sa = sx(m_acc) + sx(d); end
        else        begin s = m_acc + (255 - d) + 1; sa = sx(m_acc) - sx(d); end
        m_cout = (s > 255) ? 1 : 0;
        m_acc  = s & 255;
        m_ovf  = (sa > 127 || sa < -128) ? 1 : 0;
      end
      default: begin m_acc = 0; m_cout = 0; m_ovf = 0; end
    endcase
  endtask

  // One clock: predict the display for the coming edge, then check it after the edge
  task automatic cycle();
    logic [3:0] nib;
    if (rst) begin
      s_t = 0; s_seg = 7'h40; s_live = 1'b1;
      m_acc = 0; m_cout = 0; m_ovf = 0;
    end else begin
      nib   = 4'((m_acc >> (4 * ((s_t / SD) % DG))) & 15);
      s_seg = glyph[nib];
      s_t++;
    end
    @(posedge clk);
    @(negedge clk);
    if (done === 1'b1) n_done++;
    if (s_live) begin
      check("dig_sel", 32'(dig_sel), 32'(1 << ((s_t / SD) % DG)));
      check("seg", 32'(seg), 32'(s_seg));
    end
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    cycle();
    check("idle_done", 32'(done), 0);
    check("idle_rdy", 32'(in_ready), 1);
  endtask

  task automatic do_op(input int o, input int d, input bit junk);
    in_valid = 1'b1;
    op       = o[1:0];
    operand  = d[W-1:0];
    check("rdy_idle", 32'(in_ready), 1);
    cycle();
    check("rdy_exec", 32'(in_ready), 0);
    check("done_exec", 32'(done), 0);
    if (junk) begin
      in_valid = 1'b1;
      op       = 2'($urandom);
      operand  = W'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    cycle();
    model(o, d);
    check("acc", 32'(acc), m_acc);
    check("cout", 32'(cout), m_cout);
    check("ovf", 32'(ovf), m_ovf);
    check("done", 32'(done), 1);
    check("rdy_after", 32'(in_ready), 1);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int d0, c01, c10;
    rst = 1'b1; in_valid = 1'b1; op = 2'b00; operand = 8'hFF;
    cycle();
    cycle();
    check("rst_acc", 32'(acc), 32'h00);
    check("rst_rdy", 32'(in_ready), 1);
    check("rst_done", 32'(done), 0);
    check("rst_dig", 32'(dig_sel), 32'h1);
    check("rst_seg", 32'(seg), 32'h40);
    rst = 1'b0; in_valid = 1'b0;
    cycle();
    check("rst_prio_acc", 32'(acc), 32'h00);
    check("rst_prio_rdy", 32'(in_ready), 1);

    d0 = n_done;
    do_op(0, 8'h7F, 1'b0);
    do_op(1, 8'h01, 1'b0);
    check("ovf_acc", 32'(acc), 32'h80);
    check("ovf_flag", 32'(ovf), 1);
    check("ovf_cout", 32'(cout), 0);
    idle_cycle();
    check("ovf_done_cnt", n_done - d0, 2);

    do_op(0, 8'h05, 1'b0);
    do_op(2, 8'h07, 1'b0);
    check("sub_acc", 32'(acc), 32'hFE);
    check("sub_cout", 32'(cout), 0);
    check("sub_ovf", 32'(ovf), 0);
    idle_cycle();
    check("hold_cout", 32'(cout), 0);
    do_op(0, 8'h01, 1'b0);
    do_op(1, 8'hFF, 1'b0);
    check("wrap_acc", 32'(acc), 32'h00);
    check("wrap_cout", 32'(cout), 1);
    check("wrap_ovf", 32'(ovf), 0);

    do_op(3, 0, 1'b0);
    check("clr_acc", 32'(acc), 0);
    d0 = n_done;
    in_valid = 1'b1; op = 2'b01; operand = 8'h01;
    for (int k = 0; k < 6; k++) begin
      check("hold_rdy", 32'(in_ready), (k % 2 == 0) ? 1 : 0);
      cycle();
      if (k % 2 == 1) model(1, 1);
    end
    in_valid = 1'b0;
    cycle();
    check("hold_acc", 32'(acc), 32'h03);
    check("hold_done_cnt", n_done - d0, 3);

    do_op(0, 8'h20, 1'b0);
    in_valid = 1'b1; op = 2'b01; operand = 8'h10;
    cycle();
    check("abort_rdy_exec", 32'(in_ready), 0);
    in_valid = 1'b0; rst = 1'b1;
    d0 = n_done;
    cycle();
    rst = 1'b0;
    check("abort_acc", 32'(acc), 32'h00);
    check("abort_done", 32'(done), 0);
    check("abort_rdy", 32'(in_ready), 1);
    cycle();
    check("abort_done2", 32'(done), 0);
    check("abort_done_cnt", n_done - d0, 0);

    do_op(0, 8'hA3, 1'b0);
    cycle();
    c01 = 0; c10 = 0;
    for (int k = 0; k < 16; k++) begin
      cycle();
      if (dig_sel == 2'b01 && seg == 7'b0110000) c01++;
      if (dig_sel == 2'b10 && seg == 7'b0001000) c10++;
    end
    check("scan_lo_cnt", c01, 6);
    check("scan_hi_cnt", c10, 6);

    for (int i = 0; i < 60; i++) begin
      int o, d, g;
      o = int'($urandom_range(0, 3));
      if (o == 3 && $urandom_range(0, 1) == 1) o = 1;
      d = int'($urandom_range(0, 255));
      do_op(o, d, 1'($urandom_range(0, 1)));
      g = int'($urandom_range(0, 2));
      for (int j = 0; j < g; j++) idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/addsub_accum_seg.md
ADDSUB_ACCUM_SEG -- requirements
Module: addsub_accum_seg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the accumulator and operand width (4 to 32).
REQ-002 The block SHALL have parameter SCAN_DIV, default 4, setting the clock cycles each display digit is held (>=1).
REQ-003 The block SHALL have derived localparam DIGITS = ceil(WIDTH/4).
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port in_valid, input, 1 bit: an operation is offered.
REQ-007 Port in_ready, output, 1 bit: the block can accept an operation.
REQ-008 Port op, input, 2 bits: 00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
REQ-009 Port operand, input, WIDTH bits: unsigned/two's-complement operand.
REQ-010 Port acc, output, WIDTH bits: registered accumulator.
REQ-011 Port cout, output, 1 bit: carry out of the MSB of the last arithmetic op.
REQ-012 Port ovf, output, 1 bit: signed overflow of the last arithmetic op.
REQ-013 Port done, output, 1 bit: one-cycle completion pulse.
REQ-014 Port seg, output, 7 bits: active-low segments, bit0=a ... bit6=g.
REQ-015 Port dig_sel, output, DIGITS bits: one-hot active-high digit enable.

Function
REQ-016 FSM states: IDLE and EXEC; in_ready SHALL be 1 in IDLE and 0 in EXEC.
REQ-017 On a rising edge with state IDLE and in_valid=1, the block SHALL capture op and operand and enter EXEC; in_valid in EXEC SHALL be ignored.
REQ-018 On the edge leaving EXEC, the block SHALL update acc/cout/ovf, return to IDLE, and drive done=1 for exactly the following cycle (accept-to-result latency 2 edges; max one op per 2 cycles).
REQ-019 ADD: {cout,acc} = acc + operand, modulo 2^WIDTH wrap.
REQ-020 SUB: acc = acc + ~operand + 1; cout = carry of that sum (1 = no borrow).
REQ-021 ADD/SUB: ovf = 1 when both effective addends share a sign bit differing from the result sign bit.
REQ-022 LOAD: acc = operand, cout = 0, ovf = 0.
REQ-023 CLEAR: acc = 0, cout = 0, ovf = 0.
REQ-024 cout and ovf SHALL hold their values until the next completed op.
REQ-025 Scanner: a counter SHALL advance the digit index every SCAN_DIV cycles, wrapping DIGITS-1 -> 0; dig_sel = one-hot of the index.
REQ-026 seg SHALL be registered, showing hex glyph (0-9, A, b, C, d, E, F) of acc nibble [4*i+3:4*i] for index i, one cycle after index/acc change.
REQ-027 Nibble bits above WIDTH-1 SHALL read as 0.
REQ-028 The scanner SHALL run independently of the FSM and never stall the handshake.

Reset
REQ-029 While rst=1 at an edge: state=IDLE, acc=0, cout=0, ovf=0, done=0, scan counter=0, index=0, dig_sel=1, seg=7'b1000000 (glyph 0).
REQ-030 rst asserted during EXEC SHALL abort the op: no acc update, no done pulse.
REQ-031 rst SHALL take priority over any simultaneous in_valid.

Verification (WIDTH=8, SCAN_DIV=4)
REQ-032 Reset for 2 cycles -> acc=0x00, in_ready=1, done=0, dig_sel=2'b01, seg=7'b1000000.
REQ-033 LOAD 0x7F, then ADD 0x01 -> acc=0x80, ovf=1, cout=0, done pulses once per op, 2 edges after accept.
REQ-034 LOAD 0x05, then SUB 0x07 -> acc=0xFE, cout=0, ovf=0; LOAD 0x01, ADD 0xFF -> acc=0x00, cout=1, ovf=0.
REQ-035 in_valid held high continuously with ops ADD 0x01 x3 from acc=0 -> accepts every 2nd cycle only, in_ready=0 in EXEC, final acc=0x03, exactly 3 done pulses.
REQ-036 rst asserted in the EXEC cycle of ADD 0x10 from acc=0x20 -> acc=0x00, no done pulse, in_ready=1 next cycle.
REQ-037 acc=0xA3 -> dig_sel=01 with seg=7'b0110000 and dig_sel=10 with seg=7'b0001000, alternating every 4 cycles.
